// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, field limits and time record for the stopwatch core.
// Rev 1.0
`default_nettype none

package stopwatch_pkg;

  localparam int CSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;

  localparam int CSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 6;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2
  } sw_state_e;

  typedef struct packed {
    logic [CSEC_W-1:0] csec;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
  } sw_time_t;

endpackage

`default_nettype wire

// File: rtl/sw_mod_counter.sv
// sw_mod_counter: modulo-(MAX+1) counter whose carry fires on the increment that wraps it.
// Rev 1.0
`default_nettype none

module sw_mod_counter #(
  parameter int MAX = 9,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_value,
  output logic         o_carry
);

  localparam logic [W-1:0] c_max = W'(MAX);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         w_at_max;

  assign w_at_max = (value_q == c_max);

  always_comb begin
    value_d = value_q;
    if (i_clr) begin
      value_d = '0;
    end else if (i_inc) begin
      value_d = w_at_max ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  // Carry is combinational so the whole cascade advances on the same tick edge.
  assign o_carry = i_inc & w_at_max;
  assign o_value = value_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core: prescaled hh:mm:ss.cc counter with run/stop/lap control and display mux.
// Rev 1.0
`default_nettype none

module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int HOUR_MAX    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_runstop,
  input  logic              i_clear,
  input  logic              i_lap,
  input  logic              i_option,
  output logic [CSEC_W-1:0] o_csec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic [6:0]        o_low_digit,
  output logic [5:0]        o_high_digit,
  output logic              o_running,
  output logic              o_lap,
  output logic              o_overflow
);

  localparam int DIV     = CLK_FREQ_HZ / TICK_HZ;
  localparam int PRESC_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(DIV - 1);

  sw_state_e          state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  sw_time_t           snap_q, snap_d;
  logic               overflow_q, overflow_d;

  logic     w_active;
  logic     w_tick;
  logic     w_clear;
  logic     w_capture;
  logic     w_csec_carry, w_sec_carry, w_min_carry, w_hour_carry;
  sw_time_t w_live;
  sw_time_t w_disp;

  always_comb begin
    state_d   = state_q;
    w_clear   = 1'b0;
    w_capture = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (i_clear) begin
          w_clear = 1'b1;
        end else if (i_runstop) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_runstop) begin
          state_d = ST_STOP;
        end else if (i_lap) begin
          state_d   = ST_LAP;
          w_capture = 1'b1;
        end
      end
      ST_LAP: begin
        if (i_runstop) begin
          state_d = ST_STOP;
        end else if (i_lap) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  assign w_active = (state_q != ST_STOP);
  assign w_tick   = w_active & (presc_q == c_presc_last);

  // Prescaler freezes in STOP so a resume keeps the partial tick.
  always_comb begin
    presc_d = presc_q;
    if (w_clear) begin
      presc_d = '0;
    end else if (w_active) begin
      presc_d = w_tick ? '0 : presc_q + 1'b1;
    end
  end

  sw_mod_counter #(.MAX(CSEC_MAX), .W(CSEC_W)) u_csec (
    .clk(clk), .rst(rst), .i_inc(w_tick), .i_clr(w_clear),
    .o_value(w_live.csec), .o_carry(w_csec_carry)
  );

  sw_mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .i_inc(w_csec_carry), .i_clr(w_clear),
    .o_value(w_live.sec), .o_carry(w_sec_carry)
  );

  sw_mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .rst(rst), .i_inc(w_sec_carry), .i_clr(w_clear),
    .o_value(w_live.min), .o_carry(w_min_carry)
  );

  sw_mod_counter #(.MAX(HOUR_MAX - 1), .W(HOUR_W)) u_hour (
    .clk(clk), .rst(rst), .i_inc(w_min_carry), .i_clr(w_clear),
    .o_value(w_live.hour), .o_carry(w_hour_carry)
  );

  always_comb begin
    snap_d     = w_capture ? w_live : snap_q;
    overflow_d = w_hour_carry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      snap_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      snap_q     <= snap_d;
      overflow_q <= overflow_d;
    end
  end

  assign w_disp = (state_q == ST_LAP) ? snap_q : w_live;

  assign o_csec       = w_live.csec;
  assign o_sec        = w_live.sec;
  assign o_min        = w_live.min;
  assign o_hour       = w_live.hour;
  assign o_low_digit  = i_option ? {1'b0, w_disp.min} : w_disp.csec;
  assign o_high_digit = i_option ? w_disp.hour : w_disp.sec;
  assign o_running    = w_active;
  assign o_lap        = (state_q == ST_LAP);
  assign o_overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_lap_core.sv
// tb_stopwatch_lap_core: directed stimulus with a centisecond-total reference model checked every cycle.
// Rev 1.0
`default_nettype none

module tb_stopwatch_lap_core;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int TICK_HZ     = 100;
  localparam int HOUR_MAX    = 2;
  localparam int DIV         = CLK_FREQ_HZ / TICK_HZ;
  localparam int FULL        = HOUR_MAX * 360000;

  logic       clk;
  logic       rst;
  logic       i_runstop, i_clear, i_lap, i_option;
  logic [6:0] o_csec;
  logic [5:0] o_sec, o_min, o_hour;
  logic [6:0] o_low_digit;
  logic [5:0] o_high_digit;
  logic       o_running, o_lap, o_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  stopwatch_lap_core #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .TICK_HZ(TICK_HZ),
    .HOUR_MAX(HOUR_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_runstop(i_runstop), .i_clear(i_clear), .i_lap(i_lap), .i_option(i_option),
    .o_csec(o_csec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_low_digit(o_low_digit), .o_high_digit(o_high_digit),
    .o_running(o_running), .o_lap(o_lap), .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: elapsed time as a single centisecond total plus a sub-tick phase.
  bit m_run = 0, m_lapm = 0, m_ovf = 0;
  int m_total = 0, m_frac = 0, m_snap = 0;
  bit preset_req = 0;
  int preset_total = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 0; m_lapm <= 0; m_ovf <= 0;
      m_total <= 0; m_frac <= 0; m_snap <= 0;
    end else begin : upd
      int t, f;
      bit o;
      t = m_total; f = m_frac; o = 0;
      if (preset_req) begin
        t = preset_total;
      end else if (!m_run && i_clear) begin
        t = 0; f = 0;
      end else if (m_run) begin
        if (f == DIV - 1) begin
          f = 0;
          if (t == FULL - 1) begin t = 0; o = 1; end
          else t = t + 1;
        end else begin
          f = f + 1;
        end
      end
      m_total <= t; m_frac <= f; m_ovf <= o;
      if (!m_run) begin
        if (!i_clear && i_runstop) m_run <= 1;
      end else if (i_runstop) begin
        m_run <= 0; m_lapm <= 0;
      end else if (i_lap) begin
        if (!m_lapm) m_snap <= m_total;
        m_lapm <= !m_lapm;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int d;
    d = m_lapm ? m_snap : m_total;
    check("csec",    o_csec,     m_total % 100);
    check("sec",     o_sec,      (m_total / 100) % 60);
    check("min",     o_min,      (m_total / 6000) % 60);
    check("hour",    o_hour,     m_total / 360000);
    check("running", o_running,  m_run);
    check("lap",     o_lap,      m_lapm);
    check("ovf",     o_overflow, m_ovf);
    check("low",     o_low_digit,  i_option ? (d / 6000) % 60 : d % 100);
    check("high",    o_high_digit, i_option ? d / 360000 : (d / 100) % 60);
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) i_runstop = 1'b1;
    else if (which == 1) i_clear = 1'b1;
    else i_lap = 1'b1;
    step(1);
    i_runstop = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
  endtask

  task automatic wait_csec(input int v);
    int k;
    k = 0;
    while (o_csec != 7'(v) && k < 2000) begin
      step(1);
      k++;
    end
    check("wait_csec_timeout", int'(o_csec), v);
  endtask

  localparam int RS = 0, CL = 1, LP = 2;

  initial begin
    rst = 1'b0; i_runstop = 0; i_clear = 0; i_lap = 0; i_option = 0;
    step(3);
    check("reset_csec", o_csec, 0);
    check("reset_running", o_running, 0);
    check("reset_low", o_low_digit, 0);
    rst = 1'b1;
    step(2);

    // Start latency
    pulse(RS);
    check("start_running", o_running, 1);
    step(9);
    check("start_pre_tick", o_csec, 0);
    step(1);
    check("start_csec1", o_csec, 1);
    step(40);
    check("start_csec5", o_csec, 5);

    // Stop, clear, then stop/resume keeps the sub-tick fraction
    pulse(RS);
    pulse(CL);
    check("clear_zero", o_csec, 0);
    pulse(RS);
    step(24);
    pulse(RS);
    step(100);
    check("stop_hold", o_csec, 2);
    pulse(RS);
    step(4);
    check("resume_pre", o_csec, 2);
    step(1);
    check("resume_tick", o_csec, 3);

    pulse(CL);
    check("clear_ignored_run", o_running, 1);

    // Lap capture and release
    wait_csec(37);
    pulse(LP);
    check("lap_flag", o_lap, 1);
    check("lap_low", o_low_digit, 37);
    step(20);
    check("lap_frozen", o_low_digit, 37);
    check("lap_live", o_csec, 39);
    i_option = 1'b1;
    step(1);
    check("lap_opt_low", o_low_digit, 0);
    i_option = 1'b0;
    pulse(LP);
    check("lap_release", o_lap, 0);
    step(5);

    // Clear beats runstop in STOP
    pulse(RS);
    i_clear = 1'b1; i_runstop = 1'b1;
    step(1);
    i_clear = 1'b0; i_runstop = 1'b0;
    check("collide_csec", o_csec, 0);
    check("collide_stop", o_running, 0);
    step(2);

    // Full-scale wrap: preload 1:59:59.99 while stopped
    @(negedge clk);
    #1;
    force dut.u_csec.value_q = 7'd99;
    force dut.u_sec.value_q  = 6'd59;
    force dut.u_min.value_q  = 6'd59;
    force dut.u_hour.value_q = 6'd1;
    preset_total = FULL - 1;
    preset_req = 1'b1;
    @(posedge clk);
    #2;
    release dut.u_csec.value_q;
    release dut.u_sec.value_q;
    release dut.u_min.value_q;
    release dut.u_hour.value_q;
    preset_req = 1'b0;
    step(2);
    check("preset_hour", o_hour, 1);
    pulse(RS);
    step(9);
    check("wrap_pre_ovf", o_overflow, 0);
    check("wrap_pre_csec", o_csec, 99);
    step(1);
    check("wrap_ovf", o_overflow, 1);
    check("wrap_hour", o_hour, 0);
    check("wrap_csec", o_csec, 0);
    step(1);
    check("wrap_ovf_end", o_overflow, 0);

    // Asynchronous reset in LAP, between edges
    step(3);
    pulse(LP);
    check("pre_rst_lap", o_lap, 1);
    step(12);
    #1;
    rst = 1'b0;
    #1;
    check("async_running", o_running, 0);
    check("async_lap", o_lap, 0);
    check("async_csec", o_csec, 0);
    check("async_ovf", o_overflow, 0);
    step(1);
    rst = 1'b1;
    step(3);
    check("post_rst_stop", o_running, 0);
    check("post_rst_csec", o_csec, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
